lcd_seq_ctrl: RTL
=================

# lcd_seq_ctrl

Sequencer for the HD44780-style 16x2 character LCD. After power-on it runs the controller init sequence. It then writes line 1 by stepping the mode-text character ROM (`lcd_control`) through positions 0..15 and driving each returned byte onto the LCD bus with a correctly timed E strobe. It sits between the top-level mode FSM and the LCD pins, and is the only block that drives the ROM's `mode`/`cnt` inputs.

## Interface
- `CLK_DIV`, default 50: clock cycles per LCD tick (minimum 2).
- `POWERON_TICKS`, default 2000: ticks waited after reset before the first command.
- `CLEAR_TICKS`, default 200: extra ticks waited after the clear command (0x01).
- `REFRESH_TICKS`, default 10000: idle ticks between periodic rewrites (used only with `LCD_REFRESH_EN`).
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 2: requested display mode from the top-level FSM.
- `char_data` in 8: ASCII byte returned by the ROM for (`rom_mode`, `char_idx`).
- `rom_mode` out 2: mode presented to the ROM, latched per line write.
- `char_idx` out 4: character position presented to the ROM.
- `lcd_e` out 1: LCD enable strobe.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: tied 0 (write only).
- `lcd_data` out 8: LCD data bus.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Tick prescaler: free-running counter 0..CLK_DIV-1. The tick pulses for one cycle when the count equals CLK_DIV-1. The counter is cleared by reset. All FSM transitions occur only on a tick.
- Every bus transfer ("step") uses 3 ticks: SETUP (E=0), PULSE (E=1), HOLD (E=0).
- `lcd_rs`, `char_idx` and the data source are set on the tick that enters SETUP.
- `lcd_data` reloads every clock during SETUP, from either the command constant or `char_data`. It is frozen through PULSE and HOLD.
- States and transitions:
  - POWERON: wait POWERON_TICKS, then go to INIT.
  - INIT: command steps 0x38, 0x0C, 0x06, 0x01 in that order (rs=0), then go to CLR_WAIT.
  - CLR_WAIT: wait CLEAR_TICKS, then go to ADDR.
  - ADDR: on entry `rom_mode`<=`mode`. Command step 0x80 (rs=0), then go to CHAR with k=0.
  - CHAR: data step with `char_idx`=k (rs=1). If k<15, advance k. After k=15 HOLD: if `mode`≠`rom_mode`, go to ADDR; otherwise go to IDLE.
  - IDLE: E=0. If `mode`≠`rom_mode`, go to ADDR on the next tick.
- A mode change during POWERON, INIT or a line write is not acted on mid-line. It is picked up at the end of the line, so the LCD never shows a mixed line.
- Multiple mode changes during one line: only the value present at the end of the line is used.
- Reset mid-operation: all outputs return to reset values immediately, and the full init sequence repeats.

## Timing
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `char_idx`=0, `rom_mode`=2'b00, `busy`=1. State is POWERON with all counters 0.
- Step timing: E high for exactly CLK_DIV cycles. Data is stable for CLK_DIV cycles before E rises and CLK_DIV cycles after E falls.
- Line write: 17 steps = 51 ticks, from the ADDR entry tick to the IDLE entry tick.
- First IDLE after reset release: POWERON_TICKS + 12 + CLEAR_TICKS + 51 ticks.
- Mode-change latency from IDLE: ≤1 tick to ADDR entry, then 51 ticks to IDLE.
- `busy` falls on the clock of IDLE entry and rises on the clock of leaving IDLE.

## Configuration
- `LCD_REFRESH_EN` defined: IDLE counts ticks. When the count reaches REFRESH_TICKS it goes to ADDR and rewrites line 1 with the current `mode`. The count resets on every IDLE entry, and a mode change takes priority.
- `LCD_REFRESH_EN` undefined: IDLE is left only on a mode change. The refresh counter is not built.

## Test plan
- Reset, CLK_DIV=4, POWERON_TICKS=5, CLEAR_TICKS=3:
  - Bus shows 0x38, 0x0C, 0x06, 0x01, 0x80, each with rs=0 and a 4-cycle E pulse.
  - Then 16 rs=1 bytes "MODE1: WATCH" + 4 spaces, using the real `lcd_control` ROM.
  - `busy` falls at tick 5+12+3+51.
- In IDLE, set `mode`=2'b10: `busy` rises within 1 tick, `rom_mode`=2'b10, 0x80 is written, then "MODE3: STOP" + 5 spaces.
- Change `mode` 00→01 at char k=6 of a line: that line completes with the old text, then `rom_mode`=01, ADDR is re-entered, and "MODE2: ALARM" is written.
- Assert `rst` during a PULSE: `lcd_e` goes to 0 and `lcd_data` to 0x00 asynchronously, and the full init sequence repeats after release.
- Pulse `mode` 00→11→00 within one line: the line ends with `rom_mode`=00 equal to `mode`, so the FSM goes to IDLE with no rewrite.
- With `LCD_REFRESH_EN`, REFRESH_TICKS=20 and mode constant: the line is rewritten every 20 idle ticks. Without the macro: no bus activity after the first IDLE.

Source files
------------

// File: rtl/lcd_seq_ctrl.sv
// rtl/lcd_seq_ctrl.sv - HD44780 16x2 init sequencer and line-1 writer driving the lcd_control ROM.
// Optional periodic line rewrite from IDLE is enabled by defining LCD_REFRESH_EN.
module lcd_seq_ctrl #(
    parameter int CLK_DIV       = 50,
    parameter int POWERON_TICKS = 2000,
    parameter int CLEAR_TICKS   = 200,
    parameter int REFRESH_TICKS = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [7:0] char_data,
    output logic [1:0] rom_mode,
    output logic [3:0] char_idx,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       busy
);

    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int WAIT_BASE = (POWERON_TICKS > CLEAR_TICKS) ? POWERON_TICKS : CLEAR_TICKS;
`ifdef LCD_REFRESH_EN
    localparam int WAIT_MAX  = (REFRESH_TICKS > WAIT_BASE) ? REFRESH_TICKS : WAIT_BASE;
`else
    localparam int WAIT_MAX  = WAIT_BASE;
`endif
    localparam int WAIT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        ST_POWERON, ST_INIT, ST_CLR_WAIT, ST_ADDR, ST_CHAR, ST_IDLE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_PULSE, PH_HOLD
    } phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          init_idx_q, init_idx_d;
    logic [1:0]          rom_mode_q, rom_mode_d;
    logic [3:0]          char_idx_q, char_idx_d;
    logic                e_q, e_d;
    logic                rs_q, rs_d;
    logic [7:0]          data_q, data_d;
    logic                tick;
    logic                step_done;
    logic                start_line;
    logic [7:0]          cmd_byte;

    assign tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wait_d     = wait_q;
        init_idx_d = init_idx_q;
        rom_mode_d = rom_mode_q;
        char_idx_d = char_idx_q;
        e_d        = e_q;
        rs_d       = rs_q;
        data_d     = data_q;
        step_done  = 1'b0;
        start_line = 1'b0;
        cmd_byte   = 8'h00;

        if (tick) begin
            case (state_q)
                ST_POWERON: begin
                    if (wait_q == WAIT_W'(POWERON_TICKS - 1)) begin
                        state_d    = ST_INIT;
                        phase_d    = PH_SETUP;
                        init_idx_d = 2'd0;
                        rs_d       = 1'b0;
                        wait_d     = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_INIT, ST_ADDR, ST_CHAR: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_d = PH_PULSE;
                            e_d     = 1'b1;
                        end
                        PH_PULSE: begin
                            phase_d = PH_HOLD;
                            e_d     = 1'b0;
                        end
                        default: step_done = 1'b1;
                    endcase
                end
                ST_CLR_WAIT: begin
                    if (wait_q == WAIT_W'(CLEAR_TICKS - 1)) begin
                        wait_d     = '0;
                        start_line = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (mode != rom_mode_q) begin
                        start_line = 1'b1;
`ifdef LCD_REFRESH_EN
                    end else if (wait_q == WAIT_W'(REFRESH_TICKS - 1)) begin
                        start_line = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
`endif
                    end
                end
                default: state_d = ST_POWERON;
            endcase

            if (step_done) begin
                case (state_q)
                    ST_INIT: begin
                        if (init_idx_q == 2'd3) begin
                            state_d = ST_CLR_WAIT;
                            wait_d  = '0;
                        end else begin
                            init_idx_d = init_idx_q + 2'd1;
                            phase_d    = PH_SETUP;
                        end
                    end
                    ST_ADDR: begin
                        state_d    = ST_CHAR;
                        phase_d    = PH_SETUP;
                        char_idx_d = 4'd0;
                        rs_d       = 1'b1;
                    end
                    ST_CHAR: begin
                        if (char_idx_q == 4'd15) begin
                            // Mode is only sampled here, so a line is never mixed.
                            if (mode != rom_mode_q) begin
                                start_line = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                wait_d  = '0;
                            end
                        end else begin
                            char_idx_d = char_idx_q + 4'd1;
                            phase_d    = PH_SETUP;
                        end
                    end
                    default: ;
                endcase
            end

            if (start_line) begin
                state_d    = ST_ADDR;
                phase_d    = PH_SETUP;
                rom_mode_d = mode;
                rs_d       = 1'b0;
            end
        end

        case (state_d)
            ST_ADDR: cmd_byte = 8'h80;
            ST_INIT: begin
                case (init_idx_d)
                    2'd0:    cmd_byte = 8'h38;
                    2'd1:    cmd_byte = 8'h0C;
                    2'd2:    cmd_byte = 8'h06;
                    default: cmd_byte = 8'h01;
                endcase
            end
            default: cmd_byte = 8'h00;
        endcase

        // ROM data follows char_idx one clock late; later SETUP clocks pick it up.
        if ((state_d == ST_INIT || state_d == ST_ADDR || state_d == ST_CHAR) &&
            phase_d == PH_SETUP) begin
            data_d = rs_d ? char_data : cmd_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            state_q    <= ST_POWERON;
            phase_q    <= PH_SETUP;
            wait_q     <= '0;
            init_idx_q <= 2'd0;
            rom_mode_q <= 2'b00;
            char_idx_q <= 4'd0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            div_cnt_q  <= tick ? '0 : div_cnt_q + DIV_W'(1);
            state_q    <= state_d;
            phase_q    <= phase_d;
            wait_q     <= wait_d;
            init_idx_q <= init_idx_d;
            rom_mode_q <= rom_mode_d;
            char_idx_q <= char_idx_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
        end
    end

    assign rom_mode = rom_mode_q;
    assign char_idx = char_idx_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
